dff_pipe: RTL and testbench

DFF_PIPE -- requirements
Module: dff_pipe

---
 rtl/dff_pipe.sv | 117 +++++++++++
 tb/tb_dff_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// dff_pipe: elastic register pipeline of DEPTH stages, WIDTH bits per word.
// Each stage has a valid bit and a data register. A backward ready chain lets
// bubbles collapse and sustains one word per cycle under simultaneous push/pop.
// flush drops every word in flight; RST empties the pipe and zeroes the data.
// Optional feature: define DFF_PIPE_CNT_EN to add the registered occupancy
// output cnt (number of valid stages).
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush
`ifdef DFF_PIPE_CNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] cnt
`endif
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   r;
  logic [DEPTH-1:0] v_in;
  logic [DEPTH-1:0] v_nxt;

  // Ready chain: a stage can load when it is empty or the stage after it moves.
  // Built with a running accumulator so r never feeds back on itself.
  always_comb begin
    logic acc;
    r        = '0;
    acc      = out_ready;
    r[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc  = !v[k] || acc;
      r[k] = acc;
    end
  end

  // Incoming valid per stage and next-state valid vector (flush empties all).
  always_comb begin
    v_in    = '0;
    v_nxt   = '0;
    v_in[0] = in_valid && !flush;
    for (int k = 1; k < DEPTH; k++) begin
      v_in[k] = v[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (flush) begin
        v_nxt[k] = 1'b0;
      end else if (r[k]) begin
        v_nxt[k] = v_in[k];
      end else begin
        v_nxt[k] = v[k];
      end
    end
  end

  assign in_ready  = r[0] && !flush;
  assign out_valid = v[DEPTH-1] && !flush;
  assign dout      = d[DEPTH-1];

  // Stage valid bits; reset wins over flush and any handshake.
  always_ff @(posedge clk) begin
    if (RST) begin
      v <= '0;
    end else begin
      v <= v_nxt;
    end
  end

  // Stage data: load only when the stage advances with a real word; hold on flush.
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= '0;
      end
    end else if (!flush) begin
      if (r[0] && v_in[0]) begin
        d[0] <= din;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (r[k] && v_in[k]) begin
          d[k] <= d[k-1];
        end
      end
    end
  end

`ifdef DFF_PIPE_CNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  function automatic logic [CW-1:0] count_ones(input logic [DEPTH-1:0] bits);
    logic [CW-1:0] n;
    n = '0;
    for (int k = 0; k < DEPTH; k++) begin
      n = n + CW'(bits[k]);
    end
    return n;
  endfunction

  // Occupancy tracks the valid vector it will hold after this edge.
  always_ff @(posedge clk) begin
    if (RST) begin
      cnt <= '0;
    end else begin
      cnt <= count_ones(v_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed stimulus for dff_pipe (WIDTH=8, DEPTH=4) with a
// scoreboard queue fed on accepted words and drained on delivered words.
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] din;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dout;
  logic       out_valid;
  logic       out_ready;
  logic       flush;
`ifdef DFF_PIPE_CNT_EN
  logic [2:0] cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  dff_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .RST       (RST),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush)
`ifdef DFF_PIPE_CNT_EN
    ,
    .cnt       (cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs are stable from posedge+1 to the next posedge, so the
  // negedge sees exactly the handshakes the coming edge will perform.
  always @(negedge clk) begin
    if (RST || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL sb_unexpected: observed word 0x%0h expected none", dout);
        end else begin
          check("sb_data", 32'(dout), 32'(sb.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(din);
      end
    end
  end

  initial begin
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; din = 8'h00; out_ready = 1'b0;

    // Reset
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef DFF_PIPE_CNT_EN
    check("rst_cnt", 32'(cnt), 32'd0);
`endif
    RST = 1'b0;
    #1;

    // Streaming 0x01..0x08, no backpressure
    out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 8) begin
        in_valid = 1'b1;
        din      = 8'(k);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check("stream_out_valid", 32'(out_valid), 32'((k >= 4) && (k <= 11)));
      if (k >= 4 && k <= 11) check("stream_dout", 32'(dout), 32'(k - 3));
    end

    // Backpressure: only four of six offered words fit
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din      = 8'(8'h10 + i);
      in_valid = 1'b1;
      #1;
      check("bp_in_ready", 32'(in_ready), 32'(i < 4));
      tick();
    end
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_dout", 32'(dout), 32'h10);
`ifdef DFF_PIPE_CNT_EN
    check("bp_cnt", 32'(cnt), 32'd4);
`endif

    // Release: simultaneous pop and push while full
    out_ready = 1'b1;
    din       = 8'h14;
    in_valid  = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    tick();
    din = 8'h15;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rel_drained", 32'(out_valid), 32'd0);
    check("rel_sb_empty", 32'(sb.size()), 32'd0);

    // Bubble collapse under out_ready = 0
    out_ready = 1'b0;
    din = 8'hA0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    din = 8'hA1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("bub_v", 32'(dut.v), 32'b1100);
    check("bub_d3", 32'(dut.d[3]), 32'hA0);
    check("bub_d2", 32'(dut.d[2]), 32'hA1);
    check("bub_in_ready", 32'(in_ready), 32'd1);
    check("bub_dout", 32'(dout), 32'hA0);
`ifdef DFF_PIPE_CNT_EN
    check("bub_cnt", 32'(cnt), 32'd2);
`endif
    out_ready = 1'b1;
    tick();
    check("bub_second_valid", 32'(out_valid), 32'd1);
    check("bub_second_dout", 32'(dout), 32'hA1);
    tick();
    check("bub_empty", 32'(out_valid), 32'd0);

    // Flush with three words in flight and a word offered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = 8'(8'hC1 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("pre_flush_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; in_valid = 1'b1; din = 8'hEE;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("post_flush_valid", 32'(out_valid), 32'd0);
`ifdef DFF_PIPE_CNT_EN
    check("post_flush_cnt", 32'(cnt), 32'd0);
`endif
    for (int i = 0; i < 5; i++) tick();
    check("flush_never_out", 32'(out_valid), 32'd0);

    // Reset together with flush while full, then resume
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = 8'(8'hD0 + i); in_valid = 1'b1;
      tick();
    end
    check("mid_full", 32'(in_ready), 32'd0);
    RST = 1'b1; flush = 1'b1; din = 8'h55; in_valid = 1'b1;
    tick();
    RST = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'h00);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_v", 32'(dut.v), 32'd0);
`ifdef DFF_PIPE_CNT_EN
    check("mid_rst_cnt", 32'(cnt), 32'd0);
`endif
    out_ready = 1'b1;
    din = 8'h61; in_valid = 1'b1;
    tick();
    din = 8'h62;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("resume_first", 32'(dout), 32'h61);
    check("resume_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("resume_drained", 32'(out_valid), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
